// File: rtl/stream_rr_arbiter_pkg.sv
// stream_arb_pkg: shared FSM state type and elaboration-time helpers for the stream round-robin arbiter.
// Rev 1.0
`default_nettype none

package stream_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r++;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/stream_rr_arbiter_if.sv
// stream_rr_arbiter_if: request bundle from N_REQ sources plus the single down stream toward the pipeline.
// Rev 1.0
`default_nettype none

interface stream_rr_arbiter_if #(
   parameter int N_REQ    = 4,
   parameter int D_WIDTH  = 6,
   parameter int ID_WIDTH = 2
) ();

   logic [N_REQ*D_WIDTH-1:0] req_data;
   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ-1:0]         req_ready;
   logic [N_REQ-1:0]         req_enable;
   logic [D_WIDTH-1:0]       down_data;
   logic [ID_WIDTH-1:0]      down_id;
   logic                     down_valid;
   logic                     down_ready;

   // Arbiter side
   modport slave (
      input  req_data, req_valid, req_enable, down_ready,
      output req_ready, down_data, down_id, down_valid
   );

   // Environment side: requesters plus the downstream pipeline
   modport master (
      output req_data, req_valid, req_enable, down_ready,
      input  req_ready, down_data, down_id, down_valid
   );

endinterface

`default_nettype wire

// File: rtl/stream_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; first eligible index strictly after last_i, wrapping.
// Rev 1.0
`default_nettype none

module rr_pick
   import stream_arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [N_REQ-1:0]    elig_i,
   input  logic [ID_WIDTH-1:0] last_i,
   output logic [ID_WIDTH-1:0] sel_o,
   output logic                any_o
);

   logic [N_REQ-1:0]   upper;
   logic [2*N_REQ-1:0] dbl;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         upper[i] = elig_i[i] && (i > int'(last_i));
      end
      // Low half holds candidates above last; high half is the wrapped full set.
      dbl   = {elig_i, upper};
      sel_o = '0;
      for (int j = 2*N_REQ-1; j >= 0; j--) begin
         if (dbl[j]) begin
            sel_o = ID_WIDTH'((j >= N_REQ) ? (j - N_REQ) : j);
         end
      end
      any_o = |elig_i;
   end

endmodule

`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin arbiter granting up to BURST beats per requester into one registered stream.
// Rev 1.0
`default_nettype none

module stream_rr_arbiter
   import stream_arb_pkg::*;
#(
   parameter int D_WIDTH  = 6,
   parameter int N_REQ    = 4,
   parameter int ID_WIDTH = 2,
   parameter int BURST    = 4
) (
   input  logic                clk,
   input  logic                rst,
   stream_rr_arbiter_if.slave  bus
);

   localparam int CNT_W = clog2(BURST + 1);

   arb_state_t          state_q;
   logic [ID_WIDTH-1:0] last_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic                gap_q;
   logic [D_WIDTH-1:0]  down_data_q;
   logic [ID_WIDTH-1:0] down_id_q;
   logic                down_valid_q;

   logic [N_REQ-1:0]    elig;
   logic [N_REQ-1:0]    ready;
   logic                load_ok;
   logic                xfer;
   logic                burst_done;
   logic [ID_WIDTH-1:0] xfer_id;
   logic [D_WIDTH-1:0]  xfer_data;
   logic [ID_WIDTH-1:0] pick_sel;
   logic                pick_any;

   rr_pick #(
      .N_REQ    (N_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_pick (
      .elig_i (elig),
      .last_i (last_q),
      .sel_o  (pick_sel),
      .any_o  (pick_any)
   );

   // While LOCKED the held grant is always last_q, so one register serves both roles.
   always_comb begin
      elig       = bus.req_valid & bus.req_enable;
      load_ok    = !down_valid_q || bus.down_ready;
      cnt_d      = cnt_q + 1'b1;
      xfer       = 1'b0;
      xfer_id    = last_q;
      burst_done = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (load_ok && pick_any && !gap_q) begin
               xfer       = 1'b1;
               xfer_id    = pick_sel;
               burst_done = (BURST == 1);
            end
         end
         ARB_LOCKED: begin
            if (load_ok && elig[last_q]) begin
               xfer       = 1'b1;
               burst_done = (cnt_d == CNT_W'(BURST));
            end
         end
         default: ;
      endcase
      if (rst) begin
         xfer       = 1'b0;
         burst_done = 1'b0;
      end
      ready     = '0;
      xfer_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (xfer && (xfer_id == ID_WIDTH'(i))) begin
            ready[i]  = 1'b1;
            xfer_data = bus.req_data[i*D_WIDTH +: D_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         last_q       <= ID_WIDTH'(N_REQ - 1);
         cnt_q        <= '0;
         gap_q        <= 1'b0;
         down_data_q  <= '0;
         down_id_q    <= '0;
         down_valid_q <= 1'b0;
      end else begin
         // A completed burst costs one arbitration cycle before the next grant.
         gap_q <= burst_done;
         if (load_ok) begin
            down_valid_q <= xfer;
            if (xfer) begin
               down_data_q <= xfer_data;
               down_id_q   <= xfer_id;
            end
         end
         case (state_q)
            ARB_IDLE: begin
               if (xfer) begin
                  last_q <= xfer_id;
                  cnt_q  <= CNT_W'(1);
                  if (BURST > 1) begin
                     state_q <= ARB_LOCKED;
                  end
               end
            end
            ARB_LOCKED: begin
               if (xfer) begin
                  cnt_q <= cnt_d;
                  if (burst_done) begin
                     state_q <= ARB_IDLE;
                  end
               end else if (load_ok) begin
                  state_q <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = ready;
   assign bus.down_data  = down_data_q;
   assign bus.down_id    = down_id_q;
   assign bus.down_valid = down_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: directed checks of the round-robin arbiter with BURST=4 and BURST=1 instances.
// Rev 1.0
`default_nettype none

module tb_stream_rr_arbiter;

   int n_cmp = 0;
   int n_err = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   stream_rr_arbiter_if #(.N_REQ(4), .D_WIDTH(6), .ID_WIDTH(2)) a_if ();
   stream_rr_arbiter_if #(.N_REQ(4), .D_WIDTH(6), .ID_WIDTH(2)) b_if ();

   logic [3:0][5:0] da;
   logic [3:0][5:0] db;
   assign a_if.req_data = da;
   assign b_if.req_data = db;

   stream_rr_arbiter #(.D_WIDTH(6), .N_REQ(4), .ID_WIDTH(2), .BURST(4)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if)
   );

   stream_rr_arbiter #(.D_WIDTH(6), .N_REQ(4), .ID_WIDTH(2), .BURST(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if)
   );

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      a_if.req_valid = '0;
      a_if.req_enable = '0;
      a_if.down_ready = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      a_if.req_valid  = 4'b1111;
      a_if.req_enable = 4'b1111;
      a_if.down_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (a_if.down_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", a_if.down_valid); end
      n_cmp++; if (a_if.down_data !== 6'h00) begin n_err++; $display("FAIL reset_data: got %0h want 0", a_if.down_data); end
      n_cmp++; if (a_if.down_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", a_if.down_id); end
      n_cmp++; if (a_if.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", a_if.req_ready); end
   endtask

   task automatic test_single_requester();
      logic       ev [8];
      logic [5:0] ed [8];
      logic [3:0] rdy;
      int         k;
      ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      ed = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h00, 6'h05, 6'h06, 6'h00};
      do_reset();
      k = 0;
      a_if.req_enable = 4'b1111;
      a_if.down_ready = 1'b1;
      da[0] = 6'h01;
      a_if.req_valid = 4'b0001;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         rdy = a_if.req_ready;
         @(posedge clk);
         #1;
         n_cmp++; if (a_if.down_valid !== ev[cyc]) begin n_err++; $display("FAIL single_valid[%0d]: got %0b want %0b", cyc, a_if.down_valid, ev[cyc]); end
         if (ev[cyc]) begin
            n_cmp++; if (a_if.down_data !== ed[cyc]) begin n_err++; $display("FAIL single_data[%0d]: got %0h want %0h", cyc, a_if.down_data, ed[cyc]); end
            n_cmp++; if (a_if.down_id !== 2'd0) begin n_err++; $display("FAIL single_id[%0d]: got %0d want 0", cyc, a_if.down_id); end
         end
         if (rdy[0] && a_if.req_valid[0]) begin
            k++;
            da[0] = 6'(k + 1);
            if (k == 6) a_if.req_valid = 4'b0000;
         end
      end
      n_cmp++; if (k !== 6) begin n_err++; $display("FAIL single_beats: got %0d want 6", k); end
   endtask

   task automatic test_round_robin_burst1();
      logic [3:0] rdy;
      logic       exp_v;
      logic [1:0] exp_id;
      for (int i = 0; i < 4; i++) db[i] = 6'(8'h10 + i);
      b_if.req_enable = 4'b1111;
      b_if.down_ready = 1'b1;
      b_if.req_valid  = 4'b1111;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         rdy = b_if.req_ready;
         n_cmp++; if (!$onehot0(rdy)) begin n_err++; $display("FAIL rr_ready_onehot[%0d]: got %b want at most one bit", cyc, rdy); end
         @(posedge clk);
         #1;
         exp_v  = ((cyc % 2) == 0);
         exp_id = 2'((cyc / 2) % 4);
         n_cmp++; if (b_if.down_valid !== exp_v) begin n_err++; $display("FAIL rr_valid[%0d]: got %0b want %0b", cyc, b_if.down_valid, exp_v); end
         if (exp_v) begin
            n_cmp++; if (b_if.down_id !== exp_id) begin n_err++; $display("FAIL rr_id[%0d]: got %0d want %0d", cyc, b_if.down_id, exp_id); end
            n_cmp++; if (b_if.down_data !== 6'(8'h10 + exp_id)) begin n_err++; $display("FAIL rr_data[%0d]: got %0h want %0h", cyc, b_if.down_data, 6'(8'h10 + exp_id)); end
         end
      end
      b_if.req_valid = 4'b0000;
   endtask

   task automatic test_backpressure();
      do_reset();
      a_if.req_enable = 4'b1111;
      a_if.down_ready = 1'b1;
      da[1] = 6'h2A;
      a_if.req_valid = 4'b0010;
      @(posedge clk);
      #1;
      n_cmp++; if (a_if.down_valid !== 1'b1 || a_if.down_data !== 6'h2A) begin n_err++; $display("FAIL bp_first: got v=%0b d=%0h want v=1 d=2a", a_if.down_valid, a_if.down_data); end
      da[1] = 6'h15;
      a_if.down_ready = 1'b0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         n_cmp++; if (a_if.req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", cyc, a_if.req_ready); end
         @(posedge clk);
         #1;
         n_cmp++; if (a_if.down_valid !== 1'b1 || a_if.down_data !== 6'h2A || a_if.down_id !== 2'd1) begin
            n_err++; $display("FAIL bp_hold[%0d]: got v=%0b d=%0h id=%0d want v=1 d=2a id=1", cyc, a_if.down_valid, a_if.down_data, a_if.down_id);
         end
      end
      a_if.down_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (a_if.req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready: got %b want 0010", a_if.req_ready); end
      @(posedge clk);
      #1;
      n_cmp++; if (a_if.down_valid !== 1'b1 || a_if.down_data !== 6'h15 || a_if.down_id !== 2'd1) begin
         n_err++; $display("FAIL bp_next: got v=%0b d=%0h id=%0d want v=1 d=15 id=1", a_if.down_valid, a_if.down_data, a_if.down_id);
      end
   endtask

   task automatic test_enable_mask();
      logic       exp_v;
      logic [1:0] exp_id;
      do_reset();
      for (int i = 0; i < 4; i++) da[i] = 6'(8'h20 + i);
      a_if.req_enable = 4'b1010;
      a_if.down_ready = 1'b1;
      a_if.req_valid  = 4'b1111;
      for (int cyc = 0; cyc < 14; cyc++) begin
         @(posedge clk);
         #1;
         exp_v  = ((cyc % 5) != 4);
         exp_id = (((cyc / 5) % 2) == 1) ? 2'd3 : 2'd1;
         n_cmp++; if (a_if.down_valid !== exp_v) begin n_err++; $display("FAIL mask_valid[%0d]: got %0b want %0b", cyc, a_if.down_valid, exp_v); end
         if (exp_v) begin
            n_cmp++; if (a_if.down_id !== exp_id) begin n_err++; $display("FAIL mask_id[%0d]: got %0d want %0d", cyc, a_if.down_id, exp_id); end
         end
      end
   endtask

   task automatic test_valid_drop_and_reset();
      do_reset();
      da[2] = 6'h32;
      da[3] = 6'h33;
      a_if.req_enable = 4'b1111;
      a_if.down_ready = 1'b1;
      a_if.req_valid  = 4'b1100;
      for (int cyc = 0; cyc < 2; cyc++) begin
         @(posedge clk);
         #1;
         n_cmp++; if (a_if.down_valid !== 1'b1 || a_if.down_id !== 2'd2) begin n_err++; $display("FAIL drop_beat[%0d]: got v=%0b id=%0d want v=1 id=2", cyc, a_if.down_valid, a_if.down_id); end
      end
      a_if.req_valid = 4'b1000;
      @(posedge clk);
      #1;
      n_cmp++; if (a_if.down_valid !== 1'b0) begin n_err++; $display("FAIL drop_bubble: got v=%0b want 0", a_if.down_valid); end
      @(posedge clk);
      #1;
      n_cmp++; if (a_if.down_valid !== 1'b1 || a_if.down_id !== 2'd3 || a_if.down_data !== 6'h33) begin
         n_err++; $display("FAIL drop_regrant: got v=%0b id=%0d d=%0h want v=1 id=3 d=33", a_if.down_valid, a_if.down_id, a_if.down_data);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++; if (a_if.down_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %0b want 0", a_if.down_valid); end
      n_cmp++; if (a_if.down_data !== 6'h00 || a_if.down_id !== 2'd0) begin n_err++; $display("FAIL async_out: got d=%0h id=%0d want 0 0", a_if.down_data, a_if.down_id); end
      n_cmp++; if (a_if.req_ready !== 4'b0000) begin n_err++; $display("FAIL async_ready: got %b want 0000", a_if.req_ready); end
      @(posedge clk);
      #1;
      da[0] = 6'h30;
      a_if.req_valid = 4'b1111;
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (a_if.down_valid !== 1'b1 || a_if.down_id !== 2'd0 || a_if.down_data !== 6'h30) begin
         n_err++; $display("FAIL post_reset_grant: got v=%0b id=%0d d=%0h want v=1 id=0 d=30", a_if.down_valid, a_if.down_id, a_if.down_data);
      end
   endtask

   initial begin
      da = '0;
      db = '0;
      a_if.req_valid  = '0;
      a_if.req_enable = '0;
      a_if.down_ready = 1'b0;
      b_if.req_valid  = '0;
      b_if.req_enable = '0;
      b_if.down_ready = 1'b0;
      rst = 1'b1;
      test_reset();
      test_single_requester();
      test_round_robin_burst1();
      test_backpressure();
      test_enable_mask();
      test_valid_drop_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
